// File: rtl/ibex_msg_pkg.sv
// Shared types for the register-file message loader.
// States, message length type and the per-message word limit.
package ibex_msg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DISCARD
  } loader_state_e;

  typedef logic [1:0] msg_len_t;

  localparam int unsigned MsgMaxWords = 4;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO, registered full flag; 1-cycle push-to-pop latency (0 when Pass and empty).
// Writer must not push while full_o; reader pops with rready_i while rvalid_o.
module prim_fifo_sync #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter bit          Pass  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             empty, pass_through, do_push, do_pop;

  assign empty        = (cnt_q == '0);
  assign full_o       = (cnt_q == CntW'(Depth));
  assign pass_through = Pass && empty;
  assign rvalid_o     = !empty || (pass_through && wvalid_i);
  assign rdata_o      = pass_through ? wdata_i : mem_q[rptr_q];

  // A passed-through word is consumed directly and never stored.
  assign do_pop  = rready_i && !empty;
  assign do_push = wvalid_i && !full_o && !(pass_through && rready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibex_msg_rf_loader.sv
// Loads a header-described message into consecutive message-bank registers, one word/cycle.
// Beat-to-write latency 2 cycles; data stalls when FIFO full or message complete, header only in IDLE.
module ibex_msg_rf_loader
  import ibex_msg_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hdr_valid_i,
  output logic                 hdr_ready_o,
  input  logic [AddrWidth-1:0] hdr_base_i,
  input  logic [1:0]           hdr_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 rf_valid_o,
  output logic [AddrWidth-1:0] rf_addr_o,
  output logic [DataWidth-1:0] rf_data_o,
  output logic [1:0]           rf_len_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned CntW = $clog2(MsgMaxWords + 1);
  localparam logic [AddrWidth:0] MaxReg = {1'b0, {AddrWidth{1'b1}}};

  loader_state_e        state_q, state_d;
  logic [AddrWidth-1:0] base_q;
  msg_len_t             len_q;
  logic [CntW-1:0]      acc_cnt_q;
  msg_len_t             pop_cnt_q;

  logic                 fifo_full, fifo_rvalid;
  logic [DataWidth-1:0] fifo_rdata;
  logic                 hdr_hs, hdr_ok, push, pop, last_pop;
  logic [AddrWidth:0]   hdr_end;

  // One bit wider than an address so a run past the top register cannot wrap.
  assign hdr_end = {1'b0, hdr_base_i} + {{(AddrWidth - 1){1'b0}}, hdr_len_i};
  assign hdr_ok  = (hdr_base_i != '0) && (hdr_end <= MaxReg);

  assign busy_o       = (state_q != IDLE);
  assign hdr_ready_o  = (state_q == IDLE) && !done_o;
  assign hdr_hs       = hdr_valid_i && hdr_ready_o;
  assign data_ready_o = busy_o && !fifo_full && (acc_cnt_q <= CntW'(len_q));
  assign push         = data_valid_i && data_ready_o;
  assign pop          = busy_o && fifo_rvalid;
  assign last_pop     = pop && (pop_cnt_q == len_q);

  prim_fifo_sync #(
    .Width (DataWidth),
    .Depth (FifoDepth),
    .Pass  (1'b0)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (push),
    .wdata_i  (data_i),
    .full_o   (fifo_full),
    .rvalid_o (fifo_rvalid),
    .rready_i (pop),
    .rdata_o  (fifo_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:          if (hdr_hs) state_d = hdr_ok ? WRITE : DISCARD;
      WRITE, DISCARD: if (last_pop) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q     <= '0;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      rf_valid_o <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (hdr_hs) begin
        base_q    <= hdr_base_i;
        len_q     <= hdr_len_i;
        acc_cnt_q <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (push) acc_cnt_q <= acc_cnt_q + 1'b1;
        if (pop)  pop_cnt_q <= pop_cnt_q + 1'b1;
      end
      rf_valid_o <= pop && (state_q == WRITE);
      if (pop && (state_q == WRITE)) begin
        rf_addr_o <= base_q + AddrWidth'(pop_cnt_q);
        rf_data_o <= fifo_rdata;
      end
      done_o <= last_pop;
      err_o  <= last_pop && (state_q == DISCARD);
    end
  end

  assign rf_len_o = len_q;

endmodule

// File: tb/tb_ibex_msg_rf_loader.sv
// Directed bench for ibex_msg_rf_loader: logs every rf write and done/err pulse, checks against hand values.
module tb_ibex_msg_rf_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        hdr_valid_i = 1'b0;
  logic        hdr_ready_o;
  logic [4:0]  hdr_base_i = '0;
  logic [1:0]  hdr_len_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic        rf_valid_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
  logic [1:0]  rf_len_o;
  logic        busy_o, done_o, err_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_alone = 0;
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          beat_cyc;

  ibex_msg_rf_loader dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hdr_valid_i  (hdr_valid_i),
    .hdr_ready_o  (hdr_ready_o),
    .hdr_base_i   (hdr_base_i),
    .hdr_len_i    (hdr_len_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_i       (data_i),
    .rf_valid_o   (rf_valid_o),
    .rf_addr_o    (rf_addr_o),
    .rf_data_o    (rf_data_o),
    .rf_len_o     (rf_len_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rf_valid_o) begin
        wa.push_back(rf_addr_o);
        wd.push_back(rf_data_o);
        wc.push_back(cyc);
      end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      if (err_o && !done_o) err_alone++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    err_alone = 0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic hdr(input logic [4:0] b, input logic [1:0] l);
    int n = 0;
    hdr_valid_i = 1'b1;
    hdr_base_i  = b;
    hdr_len_i   = l;
    while (!hdr_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("hdr_wait", 64'(n >= 50), 0);
    @(negedge clk_i);
    hdr_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    int n = 0;
    data_valid_i = 1'b1;
    data_i       = d;
    while (!data_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("beat_wait", 64'(n >= 50), 0);
    beat_cyc = cyc;
    @(negedge clk_i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_wait", 64'(n >= 50), 0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_cyc;
    int k;
    int done_seen;
    int rdy_cyc;
    logic rdy;
    logic [31:0] d4 [6];

    repeat (3) @(negedge clk_i);
    chk("rst_hdr_ready", hdr_ready_o, 1);
    chk("rst_data_ready", data_ready_o, 0);
    chk("rst_rf_valid", rf_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_len", rf_len_o, 0);
    chk("rst_addr", rf_addr_o, 0);
    chk("rst_data", rf_data_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: four-word message to x5..x8, streamed back-to-back
    clear_log();
    hdr(5'd5, 2'd3);
    chk("t1_busy", busy_o, 1);
    chk("t1_len", rf_len_o, 3);
    for (int i = 0; i < 4; i++) begin
      beat(32'hA000_0000 + 32'(i));
      if (i == 0) first_cyc = beat_cyc;
    end
    data_valid_i = 1'b0;
    wait_idle();
    chk("t1_nwr", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wa[i], 5 + i);
      chk("t1_data", wd[i], 32'hA000_0000 + 32'(i));
      chk("t1_cyc", wc[i], first_cyc + 2 + i);
    end
    chk("t1_done", done_cnt, 1);
    chk("t1_err", err_cnt, 0);

    // 2a: x30, x31 is the last legal span
    clear_log();
    hdr(5'd30, 2'd1);
    beat(32'hB000_0000);
    beat(32'hB000_0001);
    data_valid_i = 1'b0;
    wait_idle();
    chk("t2a_nwr", wa.size(), 2);
    chk("t2a_addr0", wa[0], 30);
    chk("t2a_addr1", wa[1], 31);
    chk("t2a_data1", wd[1], 32'hB000_0001);
    chk("t2a_done", done_cnt, 1);
    chk("t2a_err", err_cnt, 0);

    // 2b: x30..x32 would run past the top register
    clear_log();
    hdr(5'd30, 2'd2);
    for (int i = 0; i < 3; i++) beat(32'hC000_0000 + 32'(i));
    data_valid_i = 1'b0;
    wait_idle();
    chk("t2b_nwr", wa.size(), 0);
    chk("t2b_done", done_cnt, 1);
    chk("t2b_err", err_cnt, 1);
    chk("t2b_err_alone", err_alone, 0);

    // 3: base x0 is rejected
    clear_log();
    hdr(5'd0, 2'd0);
    beat(32'hD000_0000);
    data_valid_i = 1'b0;
    wait_idle();
    chk("t3_nwr", wa.size(), 0);
    chk("t3_err", err_cnt, 1);
    chk("t3_done", done_cnt, 1);

    // 4: six beats offered for a four-word message
    clear_log();
    for (int i = 0; i < 6; i++) d4[i] = 32'hE000_0000 + 32'(i);
    hdr(5'd12, 2'd3);
    k = 0;
    data_valid_i = 1'b1;
    data_i = d4[0];
    for (int i = 0; i < 14; i++) begin
      rdy = data_ready_o;
      @(negedge clk_i);
      if (rdy) begin
        k++;
        data_i = d4[k];
      end
    end
    chk("t4_accepted", k, 4);
    chk("t4_ready_low", data_ready_o, 0);
    chk("t4_nwr", wa.size(), 4);
    chk("t4_addr3", wa[3], 15);
    chk("t4_data3", wd[3], d4[3]);
    hdr(5'd20, 2'd0);
    beat(d4[4]);
    data_valid_i = 1'b0;
    wait_idle();
    chk("t4_nwr_next", wa.size(), 5);
    chk("t4_addr_next", wa[4], 20);
    chk("t4_data_next", wd[4], d4[4]);

    // 5: reset after two of four beats
    hdr(5'd1, 2'd3);
    beat(32'hF000_0000);
    beat(32'hF000_0001);
    data_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("t5_rf_valid", rf_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_hdr_ready", hdr_ready_o, 1);
    chk("t5_data_ready", data_ready_o, 0);
    chk("t5_len", rf_len_o, 0);
    chk("t5_addr", rf_addr_o, 0);
    chk("t5_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_log();
    @(negedge clk_i);
    hdr(5'd10, 2'd0);
    beat(32'h1234_5678);
    data_valid_i = 1'b0;
    wait_idle();
    chk("t5_nwr", wa.size(), 1);
    chk("t5_addr10", wa[0], 10);
    chk("t5_data10", wd[0], 32'h1234_5678);

    // 6: next header held during a message
    clear_log();
    hdr(5'd15, 2'd1);
    hdr_valid_i = 1'b1;
    hdr_base_i  = 5'd17;
    hdr_len_i   = 2'd0;
    chk("t6_ready_busy", hdr_ready_o, 0);
    beat(32'h6000_0000);
    beat(32'h6000_0001);
    data_valid_i = 1'b0;
    done_seen = -1;
    rdy_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      if (hdr_ready_o) begin
        rdy_cyc = cyc;
        break;
      end
      if (done_o) done_seen = cyc;
      @(negedge clk_i);
    end
    chk("t6_ready_after_done", rdy_cyc, done_seen + 1);
    @(negedge clk_i);
    hdr_valid_i = 1'b0;
    beat(32'h6000_0002);
    data_valid_i = 1'b0;
    wait_idle();
    chk("t6_nwr", wa.size(), 3);
    chk("t6_addr0", wa[0], 15);
    chk("t6_addr1", wa[1], 16);
    chk("t6_addr2", wa[2], 17);
    chk("t6_data2", wd[2], 32'h6000_0002);
    chk("t6_done", done_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
